// File: rtl/chip_pkg.sv
// Shared types and default geometry for the Chip burst sequencer.
package chip_pkg;

    localparam int CHIP_BGWIDTH      = 2;
    localparam int CHIP_BAWIDTH      = 2;
    localparam int CHIP_COLWIDTH     = 10;
    localparam int CHIP_DEVICE_WIDTH = 4;
    localparam int CHIP_BL           = 8;
    localparam int CHIP_CHWIDTH      = 5;
    localparam int CHIP_RDLAT        = 1;

    localparam int BANKGROUPS    = 2 ** CHIP_BGWIDTH;
    localparam int BANKSPERGROUP = 2 ** CHIP_BAWIDTH;
    localparam int BLWIDTH       = $clog2(CHIP_BL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                     write;
        logic [CHIP_BGWIDTH-1:0]  bg;
        logic [CHIP_BAWIDTH-1:0]  ba;
        logic [CHIP_CHWIDTH-1:0]  row;
        logic [CHIP_COLWIDTH-1:0] col;
    } cmd_t;

endpackage

// File: rtl/chip_burst_sequencer_rd_return_pipe.sv
// Read-return path: delays the per-beat {valid, bg, ba, last} tag and
// captures the addressed bank's dqout into the registered rd_* stream.
module rd_return_pipe
    import chip_pkg::*;
#(
    parameter int BGWIDTH      = CHIP_BGWIDTH,
    parameter int BAWIDTH      = CHIP_BAWIDTH,
    parameter int DEVICE_WIDTH = CHIP_DEVICE_WIDTH,
    parameter int RDLAT        = CHIP_RDLAT,
    localparam int NBG = 2 ** BGWIDTH,
    localparam int NBA = 2 ** BAWIDTH,
    localparam int TW  = 2 + BGWIDTH + BAWIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      tag_valid,
    input  logic [BGWIDTH-1:0]                        tag_bg,
    input  logic [BAWIDTH-1:0]                        tag_ba,
    input  logic                                      tag_last,
    input  logic [NBG-1:0][NBA-1:0][DEVICE_WIDTH-1:0] dqout,
    output logic                                      rd_valid,
    output logic [DEVICE_WIDTH-1:0]                   rd_data,
    output logic                                      rd_last
);

    logic [TW-1:0]      tag_s;
    logic [TW-1:0]      sel_s;
    logic               sel_valid_s;
    logic [BGWIDTH-1:0] sel_bg_s;
    logic [BAWIDTH-1:0] sel_ba_s;
    logic               sel_last_s;

    assign tag_s = {tag_valid, tag_bg, tag_ba, tag_last};

    // The output register is the final stage, so only RDLAT-1 delay stages sit in front of it.
    generate
        if (RDLAT > 1) begin : g_dly
            logic [TW-1:0] dly_r [RDLAT-1];

            // Tag delay line.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RDLAT - 1; i++) begin
                        dly_r[i] <= '0;
                    end
                end else begin
                    dly_r[0] <= tag_s;
                    for (int i = 1; i < RDLAT - 1; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end

            assign sel_s = dly_r[RDLAT-2];
        end else begin : g_nodly
            assign sel_s = tag_s;
        end
    endgenerate

    assign sel_valid_s = sel_s[TW-1];
    assign sel_bg_s    = sel_s[TW-2 -: BGWIDTH];
    assign sel_ba_s    = sel_s[BAWIDTH:1];
    assign sel_last_s  = sel_s[0];

    // Read-data output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= sel_valid_s;
            rd_last  <= sel_valid_s && sel_last_s;
            rd_data  <= sel_valid_s ? dqout[sel_bg_s][sel_ba_s] : '0;
        end
    end

endmodule

// File: rtl/chip_burst_sequencer.sv
// Expands one column command into a wrapped burst on the Chip per-bank arrays.
// Optional burst chop (4 beats) is enabled by defining BURST_CHOP_EN.
module chip_burst_sequencer
    import chip_pkg::*;
#(
    parameter int BGWIDTH      = CHIP_BGWIDTH,
    parameter int BAWIDTH      = CHIP_BAWIDTH,
    parameter int COLWIDTH     = CHIP_COLWIDTH,
    parameter int DEVICE_WIDTH = CHIP_DEVICE_WIDTH,
    parameter int BL           = CHIP_BL,
    parameter int CHWIDTH      = CHIP_CHWIDTH,
    parameter int RDLAT        = CHIP_RDLAT,
    localparam int NBG = 2 ** BGWIDTH,
    localparam int NBA = 2 ** BAWIDTH,
    localparam int BLW = $clog2(BL),
    localparam int GW  = (RDLAT > 1) ? $clog2(RDLAT) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic                                      cmd_write,
    input  logic [BGWIDTH-1:0]                        cmd_bg,
    input  logic [BAWIDTH-1:0]                        cmd_ba,
    input  logic [CHWIDTH-1:0]                        cmd_row,
    input  logic [COLWIDTH-1:0]                       cmd_col,
    input  logic [BL*DEVICE_WIDTH-1:0]                cmd_wdata,
`ifdef BURST_CHOP_EN
    input  logic                                      cmd_bc4,
`endif
    output logic [NBG-1:0][NBA-1:0]                   rd_o_wr,
    output logic [NBG-1:0][NBA-1:0][DEVICE_WIDTH-1:0] dqin,
    output logic [NBG-1:0][NBA-1:0][CHWIDTH-1:0]      row,
    output logic [NBG-1:0][NBA-1:0][COLWIDTH-1:0]     column,
    input  logic [NBG-1:0][NBA-1:0][DEVICE_WIDTH-1:0] dqout,
    output logic                                      rd_valid,
    output logic [DEVICE_WIDTH-1:0]                   rd_data,
    output logic                                      rd_last
);

    state_t                    state_r, state_nx_s;
    logic [BLW-1:0]            beat_r, beat_nx_s;
    logic [GW-1:0]             gap_r, gap_nx_s;
    cmd_t                      cmd_r, cmd_nx_s;
    logic [BL*DEVICE_WIDTH-1:0] wdata_r, wdata_nx_s;
    logic                      bc4_r, bc4_nx_s;
    logic                      bc4_in_s;
    logic [BLW-1:0]            last_beat_s;
    logic                      drive_s;
    logic [COLWIDTH-1:0]       col_s;
    logic [DEVICE_WIDTH-1:0]   data_s;

    // Low address bits advance modulo the burst (or 4 when chopped); upper bits never carry.
    function automatic logic [COLWIDTH-1:0] beat_column(
        input logic [COLWIDTH-1:0] base,
        input logic [BLW-1:0]      beat,
        input logic                chop
    );
        logic [BLW-1:0] lo_mask;
        logic [BLW-1:0] lo_sum;
        lo_mask = chop ? BLW'(2'd3) : {BLW{1'b1}};
        lo_sum  = base[BLW-1:0] + beat;
        return (base & ~COLWIDTH'(lo_mask)) | COLWIDTH'(lo_sum & lo_mask);
    endfunction

`ifdef BURST_CHOP_EN
    assign bc4_in_s = cmd_bc4 && (BL >= 8);
`else
    assign bc4_in_s = 1'b0;
`endif

    assign last_beat_s = bc4_r ? BLW'(2'd3) : BLW'(BL - 1);

    // Next-state, beat sequencing and selection of the beat to drive next cycle.
    always_comb begin
        state_nx_s = state_r;
        beat_nx_s  = beat_r;
        gap_nx_s   = gap_r;
        cmd_nx_s   = cmd_r;
        wdata_nx_s = wdata_r;
        bc4_nx_s   = bc4_r;
        drive_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nx_s     = ST_BURST;
                    beat_nx_s      = '0;
                    cmd_nx_s.write = cmd_write;
                    cmd_nx_s.bg    = cmd_bg;
                    cmd_nx_s.ba    = cmd_ba;
                    cmd_nx_s.row   = cmd_row;
                    cmd_nx_s.col   = cmd_col;
                    wdata_nx_s     = cmd_wdata;
                    bc4_nx_s       = bc4_in_s;
                    drive_s        = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (beat_r == last_beat_s) begin
                    state_nx_s = ST_GAP;
                    gap_nx_s   = cmd_r.write ? '0 : GW'(RDLAT - 1);
                end else begin
                    beat_nx_s = beat_r + BLW'(1'b1);
                    drive_s   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_r == '0) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    gap_nx_s = gap_r - GW'(1'b1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign col_s  = beat_column(cmd_nx_s.col, beat_nx_s, bc4_nx_s);
    assign data_s = wdata_nx_s[int'(beat_nx_s)*DEVICE_WIDTH +: DEVICE_WIDTH];

    // Sequencer state, latched command and handshake register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            beat_r    <= '0;
            gap_r     <= '0;
            cmd_r     <= '0;
            wdata_r   <= '0;
            bc4_r     <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_r   <= state_nx_s;
            beat_r    <= beat_nx_s;
            gap_r     <= gap_nx_s;
            cmd_r     <= cmd_nx_s;
            wdata_r   <= wdata_nx_s;
            bc4_r     <= bc4_nx_s;
            cmd_ready <= (state_nx_s == ST_IDLE);
        end
    end

    // Per-bank drive registers: only the addressed bank carries the beat, all others sit at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_o_wr <= '0;
            dqin    <= '0;
            row     <= '0;
            column  <= '0;
        end else begin
            for (int g = 0; g < NBG; g++) begin
                for (int b = 0; b < NBA; b++) begin
                    if (drive_s && (int'(cmd_nx_s.bg) == g) && (int'(cmd_nx_s.ba) == b)) begin
                        rd_o_wr[g][b] <= cmd_nx_s.write;
                        dqin[g][b]    <= cmd_nx_s.write ? data_s : '0;
                        row[g][b]     <= cmd_nx_s.row;
                        column[g][b]  <= col_s;
                    end else begin
                        rd_o_wr[g][b] <= 1'b0;
                        dqin[g][b]    <= '0;
                        row[g][b]     <= '0;
                        column[g][b]  <= '0;
                    end
                end
            end
        end
    end

    rd_return_pipe #(
        .BGWIDTH      (BGWIDTH),
        .BAWIDTH      (BAWIDTH),
        .DEVICE_WIDTH (DEVICE_WIDTH),
        .RDLAT        (RDLAT)
    ) u_rd_return_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_valid ((state_r == ST_BURST) && !cmd_r.write),
        .tag_bg    (cmd_r.bg),
        .tag_ba    (cmd_r.ba),
        .tag_last  (beat_r == last_beat_s),
        .dqout     (dqout),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last)
    );

endmodule

// File: doc/chip_burst_sequencer.md
Name: chip_burst_sequencer

Overview:
- Sits directly upstream of the Chip per-bank storage array.
- Accepts one column command at a time (bank group, bank, row, column, read/write) through a valid/ready handshake.
- Expands each command into a BL-beat burst on the Chip's per-bank rd_o_wr/dqin/row/column arrays.
- Collects the returning dqout beats of reads into a serial read-data stream.

Parameters:
- BGWIDTH, 2, bank-group address bits.
- BAWIDTH, 2, bank-in-group address bits.
- COLWIDTH, 10, column address bits.
- DEVICE_WIDTH, 4, DQ bits per beat.
- BL, 8, burst length; power of two, 2 or more, at most 2**COLWIDTH.
- CHWIDTH, 5, row address bits (same meaning as on Chip).
- RDLAT, 1, cycles from a read beat being driven to its data being presented on rd_data; 1 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_bg  in  BGWIDTH  target bank group.
- cmd_ba  in  BAWIDTH  target bank.
- cmd_row  in  CHWIDTH  target row.
- cmd_col  in  COLWIDTH  starting column.
- cmd_wdata  in  BL*DEVICE_WIDTH  write burst; beat k = bits [k*DEVICE_WIDTH +: DEVICE_WIDTH].
- rd_o_wr  out  1 per [BANKGROUPS][BANKSPERGROUP]  to Chip.
- dqin  out  DEVICE_WIDTH per bank  to Chip.
- row  out  CHWIDTH per bank  to Chip.
- column  out  COLWIDTH per bank  to Chip.
- dqout  in  DEVICE_WIDTH per bank  from Chip.
- rd_valid  out  1  read beat valid.
- rd_data  out  DEVICE_WIDTH  read beat.
- rd_last  out  1  final beat of the read burst.

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - State goes to IDLE; cmd_ready=1.
  - Every per-bank rd_o_wr, dqin, row and column is 0.
  - rd_valid, rd_last and rd_data are 0; the read pipeline is flushed and in-flight beats are discarded.
- States:
  - IDLE: cmd_ready=1. A command is accepted on a rising edge where cmd_valid and cmd_ready are both high. On acceptance, latch the command fields, set beat counter k=0 and go to BURST.
  - BURST: lasts BL cycles; cmd_ready=0.
    - In cycle k, only the selected bank [bg][ba] is driven: row=cmd_row, column={col_hi, (col_lo+k) mod BL}.
    - col_lo is the low log2(BL) bits of cmd_col; col_hi (the remaining upper bits) is unchanged, so the burst wraps within its aligned block.
    - Write: rd_o_wr=1 and dqin=beat k of cmd_wdata. Read: rd_o_wr=0 and dqin=0.
    - All unselected banks are held at 0.
    - After beat BL-1, go to GAP.
  - GAP: all per-bank outputs are 0. Lasts 1 cycle for a write and RDLAT cycles for a read, so the read pipeline is empty on exit. Then go to IDLE.
- Outputs are registered: a command accepted at edge N has beat 0 visible in cycle N+1 and beat BL-1 in cycle N+BL. For a write, cmd_ready rises again in cycle N+BL+2.
- cmd_valid while cmd_ready=0 is ignored; no command is queued.
- Read return: a shift pipeline of depth RDLAT carries {valid, bg, ba, last}.
  - The pipeline stage that is RDLAT-1 cycles behind beat k samples dqout[bg][ba] at the end of that cycle.
  - rd_valid/rd_data for beat k are asserted in cycle (beat k cycle)+RDLAT.
  - rd_last is high with beat BL-1 only.
  - There is no backpressure on rd_*.
- Boundary conditions:
  - cmd_col is not BL-aligned: the column sequence wraps, e.g. 5,6,7,0,1,2,3,4 for BL=8.
  - Burst in the highest column block: col_hi is never incremented.

Optional Feature:
- Macro BURST_CHOP_EN.
- When defined:
  - Extra input cmd_bc4 (1 bit), latched at acceptance.
  - If it is 1, BURST lasts 4 cycles with columns {col_hi, col_lo[ob] bit-level wrap within 4}: column = {cmd_col[COLWIDTH-1:2], (cmd_col[1:0]+k) mod 4}.
  - rd_last is asserted on beat 3 and only beats 0-3 of cmd_wdata are used.
  - The GAP rules are unchanged.
  - cmd_bc4 with BL<8 is treated as 0.
- When undefined: no cmd_bc4 port; every burst is BL beats.

Decomposition:
- Package chip_pkg holds:
  - Localparams BANKGROUPS=2**BGWIDTH, BANKSPERGROUP=2**BAWIDTH, BLWIDTH=$clog2(BL).
  - The state enum {IDLE, BURST, GAP}.
  - A command struct typedef {write, bg, ba, row, col}.
- One sub-module, rd_return_pipe: the RDLAT-deep valid/bank/last shift register plus the dqout mux and rd_* output registers.

Test Plan:
- Reset, then write bg=1, ba=1, row=1, col=0, cmd_wdata=0x89ABCDEF:
  - Bank[1][1] sees columns 0..7 in cycles N+1..N+8, with dqin = F,E,D,C,B,A,9,8 and rd_o_wr=1.
  - All other banks stay 0.
  - cmd_ready returns in cycle N+10.
- Read the same address with RDLAT=1:
  - rd_valid is high in cycles N+2..N+9 with rd_data = F,E,...,8.
  - rd_last is high only in cycle N+9.
- Write with col=0x005:
  - column sequence is 5,6,7,0,1,2,3,4.
  - column bits [9:3] stay 0.
- cmd_valid held high continuously:
  - Exactly one acceptance per burst.
  - Second command accepted in IDLE after GAP.
  - No outputs are driven during GAP.
- rst_n pulsed low at beat 3 of a read:
  - All outputs are 0 immediately (asynchronously); no further rd_valid appears.
  - cmd_ready=1 after release.
- With BURST_CHOP_EN and cmd_bc4=1, col=6, BL=8:
  - columns are 6,7,4,5.
  - rd_last is on beat 3.
  - cmd_ready returns after 4 beats plus the GAP.
